timer_sched: RTL and testbench
==============================

TIMER_SCHED -- requirements
Module: timer_sched

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, number of requesters.
REQ-002 The block SHALL have parameter CW, default 10, timer count width.
REQ-003 The block SHALL have parameter LOAD_CYC, default 1, cycles tmr_load is held high.
REQ-004 The block SHALL have parameter RST_CYC, default 2, cycles tmr_rstn is held low after each job.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset, with these ports:
- sched_clock  in  1  sole clock, rising edge.
- sched_rst  in  1  asynchronous active-high reset.
REQ-006 The block SHALL have these requester-side ports:
- req_valid  in  N_REQ  per-requester job request, held until req_ready.
- req_count  in  N_REQ*CW  flattened per-requester delay; slice i = bits [i*CW +: CW].
- req_cancel  in  N_REQ  abort own active job.
- req_ready  out  N_REQ  one-cycle accept pulse.
- done  out  N_REQ  one-cycle completion pulse.
- busy  out  1  job in service.
- cur_id  out  clog2(N_REQ)  owner of current job.
- err  out  1  sticky watchdog error.
REQ-007 The block SHALL have these timer-side ports:
- tmr_load  out  1  load strobe to shared timer.
- tmr_data  out  CW  count to shared timer.
- tmr_rstn  out  1  active-low reset to shared timer.
- tmr_out  in  1  timer expiry flag, sticky until timer reset.

Function
REQ-008 The FSM SHALL have states IDLE, LOAD, WAIT, CLEAR; all outputs SHALL be registered.
REQ-009 In IDLE with any req_valid set, the block SHALL grant round-robin, starting at the index after the last granted index (index 0 after reset).
REQ-010 On grant, the block SHALL latch req_count slice and id, and pulse req_ready[id] and assert busy in the next cycle.
REQ-011 A granted nonzero count SHALL move to LOAD; a granted zero count SHALL bypass the timer, pulse done[id] the next cycle, and return to IDLE.
REQ-012 LOAD SHALL drive tmr_load=1 and tmr_data=latched count for exactly LOAD_CYC cycles, then enter WAIT with tmr_load=0.
REQ-013 In WAIT, tmr_out=1 SHALL pulse done[cur_id] for one cycle and enter CLEAR.
REQ-014 In WAIT, req_cancel[cur_id]=1 SHALL enter CLEAR without a done pulse.
- Cancel from a non-owner SHALL be ignored.
- tmr_out and cancel in the same cycle: done wins.
REQ-015 CLEAR SHALL drive tmr_rstn=0 for exactly RST_CYC cycles, then return to IDLE with busy=0.
REQ-016 In WAIT, a watchdog counter SHALL set err if the wait exceeds latched count + 8 cycles, then enter CLEAR without done; err SHALL clear only on reset.
REQ-017 req_valid SHALL be ignored outside IDLE; a request from a non-granted requester SHALL remain pending and is not lost.
REQ-018 A requester SHALL drop or renew req_valid in the cycle after its req_ready; there SHALL be no re-grant before the job returns to IDLE.
REQ-019 Grant-to-tmr_load latency SHALL be 1 cycle; tmr_out-to-done latency SHALL be 1 cycle.

Reset
REQ-020 sched_rst SHALL asynchronously force IDLE and clear the round-robin pointer.
REQ-021 During reset, outputs SHALL be: req_ready=0, done=0, busy=0, cur_id=0, err=0, tmr_load=0, tmr_data=0, tmr_rstn=0.
REQ-022 tmr_rstn SHALL rise to 1 on the first clock edge after deassertion.
REQ-023 Reset mid-job SHALL abandon the job with no done pulse.

Structure
REQ-024 The state encoding, default parameter values, and the watchdog slack constant (8) SHALL reside in shared package timer_sched_pkg.
REQ-025 The round-robin selector SHALL be one sub-module, rr_arbiter (request vector + pointer in, one-hot grant + index out, combinational).
REQ-026 The block SHALL instantiate no timer; the existing timer is connected at the top level.

Verification
REQ-027 The bench SHALL cover these directed scenarios, with timer model attached:
- Single job: req_valid[0], count=5 -> req_ready[0] one pulse, tmr_load one cycle with tmr_data=5, done[0] one cycle after tmr_out, tmr_rstn low 2 cycles.
- Contention: req_valid=4'b1111, counts 3,4,2,6 -> grants in order 0,1,2,3; next round starts at 0; no req_valid lost.
- Cancel: owner 2, count=20, req_cancel[2] at WAIT cycle 3 -> no done[2], CLEAR entered, next grant proceeds.
- Zero count: req_valid[1], count=0 -> done[1] the cycle after req_ready[1], tmr_load never asserted.
- Watchdog: count=4, tmr_out held low -> err=1 after 12 WAIT cycles, stays 1 until sched_rst.
- Reset mid-WAIT: sched_rst asserted -> all outputs to REQ-021 values immediately, no done pulse.

Source files
------------

// File: rtl/timer_sched_pkg.sv
// timer_sched_pkg: state encoding, default parameters and watchdog slack shared by the timer scheduler
package timer_sched_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, WAIT, CLEAR} state_t;
    localparam int N_REQ_DEF    = 4;
    localparam int CW_DEF       = 10;
    localparam int LOAD_CYC_DEF = 1;
    localparam int RST_CYC_DEF  = 2;
    localparam int WD_SLACK     = 8;
endpackage

// File: rtl/timer_sched_rr.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);
    logic [IW-1:0] c;
    // scanning from the far end lets the closest request to ptr overwrite the rest
    always_comb begin
        gnt = '0;
        idx = '0;
        c = '0;
        for (int k = N - 1; k >= 0; k--) begin
            c = IW'((int'(ptr) + k) % N);
            if (req[c]) begin
                gnt = '0;
                gnt[c] = 1'b1;
                idx = c;
            end
        end
    end
endmodule

// File: rtl/timer_sched.sv
// timer_sched: round-robin scheduler sharing one external timer among requesters,
// with cancel, zero-count bypass and a sticky wait watchdog
module timer_sched
    import timer_sched_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int CW       = CW_DEF,
    parameter int LOAD_CYC = LOAD_CYC_DEF,
    parameter int RST_CYC  = RST_CYC_DEF,
    localparam int IW      = $clog2(N_REQ > 1 ? N_REQ : 2)
) (
    input  logic              sched_clock,
    input  logic              sched_rst,
    input  logic [N_REQ-1:0]  req_valid,
    input  logic [N_REQ*CW-1:0] req_count,
    input  logic [N_REQ-1:0]  req_cancel,
    output logic [N_REQ-1:0]  req_ready,
    output logic [N_REQ-1:0]  done,
    output logic              busy,
    output logic [IW-1:0]     cur_id,
    output logic              err,
    output logic              tmr_load,
    output logic [CW-1:0]     tmr_data,
    output logic              tmr_rstn,
    input  logic              tmr_out
);
    state_t state;
    logic [IW-1:0] ptr, g_idx;
    logic [N_REQ-1:0] g_onehot;
    logic [CW-1:0] cnt, g_cnt;
    logic [CW:0] wcnt;
    logic wd_hit, zpend;
    int phase;

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
        .req(req_valid),
        .ptr(ptr),
        .gnt(g_onehot),
        .idx(g_idx)
    );

    assign g_cnt  = req_count[g_idx * CW +: CW];
    assign wd_hit = wcnt == ({1'b0, cnt} + (CW + 1)'(WD_SLACK - 1));

    always_ff @(posedge sched_clock or posedge sched_rst) begin
        if (sched_rst) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            wcnt      <= '0;
            phase     <= 0;
            zpend     <= 1'b0;
            req_ready <= '0;
            done      <= '0;
            busy      <= 1'b0;
            cur_id    <= '0;
            err       <= 1'b0;
            tmr_load  <= 1'b0;
            tmr_data  <= '0;
            tmr_rstn  <= 1'b0;
        end else begin
            req_ready <= '0;
            done      <= '0;
            tmr_rstn  <= 1'b1;
            case (state)
                IDLE: begin
                    // a zero-count job finishes here without touching the timer
                    if (zpend) begin
                        done[cur_id] <= 1'b1;
                        busy         <= 1'b0;
                        zpend        <= 1'b0;
                    end else if (|req_valid) begin
                        req_ready <= g_onehot;
                        busy      <= 1'b1;
                        cur_id    <= g_idx;
                        cnt       <= g_cnt;
                        ptr       <= (g_idx == IW'(N_REQ - 1)) ? '0 : g_idx + 1'b1;
                        if (g_cnt == '0) begin
                            zpend <= 1'b1;
                        end else begin
                            state    <= LOAD;
                            tmr_load <= 1'b1;
                            tmr_data <= g_cnt;
                            phase    <= 0;
                        end
                    end
                end
                LOAD: begin
                    if (phase == LOAD_CYC - 1) begin
                        state    <= WAIT;
                        tmr_load <= 1'b0;
                        tmr_data <= '0;
                        wcnt     <= '0;
                    end else begin
                        phase <= phase + 1;
                    end
                end
                WAIT: begin
                    if (tmr_out || req_cancel[cur_id] || wd_hit) begin
                        state    <= CLEAR;
                        tmr_rstn <= 1'b0;
                        phase    <= 0;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                    if (tmr_out) done[cur_id] <= 1'b1;
                    else if (!req_cancel[cur_id] && wd_hit) err <= 1'b1;
                end
                CLEAR: begin
                    if (phase == RST_CYC - 1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        tmr_rstn <= 1'b0;
                        phase    <= phase + 1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_timer_sched.sv
// tb_timer_sched: self-checking bench for timer_sched with a behavioural shared-timer model attached
module tb_timer_sched;
    localparam int N = 4;
    localparam int CW = 10;

    typedef struct {
        int id;
        int cnt;
        int exp_load;
        int exp_dly;
        int exp_low;
    } row_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [N-1:0] req_valid = '0;
    logic [N-1:0] req_cancel = '0;
    logic [N*CW-1:0] req_count = '0;
    logic [N-1:0] req_ready, done;
    logic busy, err, tmr_load, tmr_rstn;
    logic tmr_out = 1'b0;
    logic [1:0] cur_id;
    logic [CW-1:0] tmr_data;
    logic [CW-1:0] t_cnt = '0;
    logic t_hold = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    int m_ptr = 0;

    always #5 clk = ~clk;

    timer_sched #(.N_REQ(N), .CW(CW), .LOAD_CYC(1), .RST_CYC(2)) dut (
        .sched_clock(clk),
        .sched_rst(rst),
        .req_valid(req_valid),
        .req_count(req_count),
        .req_cancel(req_cancel),
        .req_ready(req_ready),
        .done(done),
        .busy(busy),
        .cur_id(cur_id),
        .err(err),
        .tmr_load(tmr_load),
        .tmr_data(tmr_data),
        .tmr_rstn(tmr_rstn),
        .tmr_out(tmr_out)
    );

    // shared timer: loads on tmr_load, counts down, raises a sticky expiry; t_hold stalls it
    always @(posedge clk) begin
        if (!tmr_rstn) begin
            t_cnt   <= '0;
            tmr_out <= 1'b0;
        end else if (tmr_load) begin
            t_cnt <= tmr_data;
        end else if (t_cnt > 1) begin
            t_cnt <= t_cnt - 1'b1;
        end else if (t_cnt == 1 && !t_hold) begin
            t_cnt   <= '0;
            tmr_out <= 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [N-1:0] oh(input int i);
        return N'(1) << i;
    endfunction

    function automatic int rr_next(input logic [N-1:0] p, input int ptr);
        for (int k = 0; k < N; k++)
            if (p[(ptr + k) % N]) return (ptr + k) % N;
        return 0;
    endfunction

    function automatic logic [23:0] outs();
        return {req_ready, done, busy, cur_id, err, tmr_load, tmr_data, tmr_rstn};
    endfunction

    task automatic start(input int id, input int c);
        req_count[id * CW +: CW] = CW'(c);
        req_valid[id] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready != 0) break;
        end
        chk("grant", req_ready, oh(id));
        req_valid[id] = 1'b0;
        m_ptr = (id + 1) % N;
    endtask

    task automatic drain(input string nm);
        int fin;
        fin = 0;
        for (int i = 0; i < 100; i++) begin
            if (!busy) begin
                fin = 1;
                break;
            end
            @(negedge clk);
        end
        chk(nm, fin, 1);
    endtask

    task automatic run_row(input row_t r);
        int ld, dat, dly, did, nd, low, fin;
        ld = 0; dat = 0; dly = -1; did = 0; nd = 0; low = 0; fin = 0;
        start(r.id, r.cnt);
        if (tmr_load) begin
            ld++;
            dat = int'(tmr_data);
        end
        for (int i = 1; i < 100; i++) begin
            @(negedge clk);
            if (tmr_load) begin
                ld++;
                dat = int'(tmr_data);
            end
            if (done != 0) begin
                nd++;
                dly = i;
                did = int'(done);
            end
            if (!tmr_rstn) low++;
            if (!busy) begin
                fin = 1;
                break;
            end
        end
        chk("row_finish", fin, 1);
        chk("row_load_cycles", ld, r.exp_load);
        if (r.exp_load != 0) chk("row_load_data", dat, r.cnt);
        chk("row_done_pulses", nd, 1);
        chk("row_done_id", did, oh(r.id));
        chk("row_done_latency", dly, r.exp_dly);
        chk("row_rstn_low", low, r.exp_low);
    endtask

    task automatic serve(input logic [N-1:0] mask, input logic [N*CW-1:0] cnts, input bit noise);
        logic [N-1:0] pend;
        int cur, rdy, c, nd, exp_id;
        pend = mask; cur = 0; rdy = 0; c = 0; nd = 0;
        req_count = cnts;
        req_valid = mask;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            if (req_ready != 0) begin
                exp_id = rr_next(pend, m_ptr);
                chk("rr_grant", req_ready, oh(exp_id));
                cur = exp_id;
                rdy = cyc;
                c = int'(cnts[exp_id * CW +: CW]);
                pend[exp_id] = 1'b0;
                req_valid[exp_id] = 1'b0;
                m_ptr = (exp_id + 1) % N;
            end
            if (done != 0) begin
                nd++;
                chk("done_id", done, oh(cur));
                chk("done_latency", cyc - rdy, c == 0 ? 1 : c + 2);
            end
            req_cancel = noise ? (N'($urandom) & ~oh(cur)) : '0;
            if (pend == 0 && !busy) break;
        end
        req_cancel = '0;
        req_valid = '0;
        chk("all_served", {pend, 28'(nd)}, {4'b0, 28'($countones(mask))});
    endtask

    row_t rows[5] = '{
        '{0, 5,  1, 7,  2},
        '{1, 0,  0, 1,  0},
        '{2, 12, 1, 14, 2},
        '{0, 40, 1, 42, 2},
        '{3, 1,  1, 3,  2}
    };

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int nd, low;
        logic [N*CW-1:0] cv;
        #2 rst = 1'b1;
        #1 chk("reset_outputs", outs(), 0);
        repeat (2) @(negedge clk);
        chk("reset_hold", outs(), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rstn_release", tmr_rstn, 1);
        chk("idle_not_busy", busy, 0);

        foreach (rows[i]) run_row(rows[i]);

        // contention: counts 3,4,2,6 on requesters 0..3, then a second full round
        serve(4'b1111, {CW'(6), CW'(2), CW'(4), CW'(3)}, 1'b0);
        serve(4'b1111, {CW'(1), CW'(0), CW'(5), CW'(2)}, 1'b0);

        // cancel by owner 2 during WAIT cycle 3, non-owner cancel earlier is ignored
        start(2, 20);
        @(negedge clk);
        req_cancel = 4'b1011;
        @(negedge clk);
        req_cancel = '0;
        chk("nonowner_cancel_ignored", {busy, tmr_rstn}, 2'b11);
        @(negedge clk);
        req_cancel[2] = 1'b1;
        @(negedge clk);
        req_cancel[2] = 1'b0;
        chk("cancel_enters_clear", {busy, tmr_rstn, done}, {1'b1, 1'b0, 4'b0});
        nd = 0; low = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done != 0) nd++;
            if (!tmr_rstn) low++;
        end
        chk("cancel_no_done", nd, 0);
        chk("cancel_rstn_low", low, 2);
        chk("cancel_idle", busy, 0);
        serve(4'b1000, {CW'(2), CW'(0), CW'(0), CW'(0)}, 1'b0);

        // expiry and owner cancel seen in the same cycle: done wins
        start(1, 3);
        repeat (4) @(negedge clk);
        req_cancel[1] = 1'b1;
        @(negedge clk);
        req_cancel[1] = 1'b0;
        chk("done_beats_cancel", done, oh(1));
        drain("done_beats_cancel_drain");

        repeat (12) begin
            cv = '0;
            for (int j = 0; j < N; j++) cv[j * CW +: CW] = CW'($urandom_range(0, 12));
            serve(N'($urandom_range(1, 15)), cv, 1'b1);
        end

        // watchdog: count 4 with the timer stalled trips after 12 WAIT cycles
        t_hold = 1'b1;
        start(0, 4);
        repeat (12) @(negedge clk);
        chk("wd_not_yet", {err, busy}, 2'b01);
        @(negedge clk);
        chk("wd_trip", {err, tmr_rstn, done}, {1'b1, 1'b0, 4'b0});
        repeat (5) @(negedge clk);
        chk("wd_sticky_idle", {err, busy}, 2'b10);
        t_hold = 1'b0;
        serve(4'b0100, {CW'(0), CW'(3), CW'(0), CW'(0)}, 1'b0);
        chk("wd_sticky_after_job", err, 1);

        // reset in the middle of WAIT abandons the job
        start(1, 20);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1 chk("midwait_reset_outputs", outs(), 0);
        @(negedge clk);
        chk("midwait_reset_hold", outs(), 0);
        rst = 1'b0;
        m_ptr = 0;
        @(negedge clk);
        chk("midwait_release", {tmr_rstn, busy, err}, 3'b100);
        nd = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done != 0) nd++;
        end
        chk("midwait_no_done", nd, 0);
        serve(4'b1111, {CW'(2), CW'(1), CW'(0), CW'(3)}, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
